// File: rtl/rst_gen.sv
// Reset generator: holds rst_o high for RST_CYCLES clock edges after configuration
// or after the last edge at which rst_i was sampled high, then releases it synchronously.
module rst_gen #(
    parameter int RST_CYCLES = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic rst_o,
    output logic rst_n_o
);

    localparam int                CNT_W   = $clog2(RST_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RST_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    generate
        if (RST_CYCLES < 1 || RST_CYCLES > 65535) begin : g_bad_rst_cycles
            $error("rst_gen: RST_CYCLES must be in 1..65535");
        end
    endgenerate

    // Configuration values are the only reset this block has; nothing resets it at run time.
    logic [CNT_W-1:0] cnt   = '0;
    logic             rst_q = 1'b1;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt   <= '0;
            rst_q <= 1'b1;
        end else if (cnt < CNT_MAX) begin
            cnt   <= cnt + CNT_ONE;
            // Release on the same edge the count reaches its saturation value.
            rst_q <= ((cnt + CNT_ONE) != CNT_MAX);
        end
    end

    assign rst_o   = rst_q;
    assign rst_n_o = ~rst_q;

endmodule

// File: tb/tb_rst_gen.sv
// Randomized scoreboard bench for rst_gen at RST_CYCLES = 16, 1 and 65535, checked
// against a model built on "edges since the last high rst_i sample".
module tb_rst_gen;

    localparam int TOTAL = 65600;
    localparam int N16   = 16;
    localparam int N1    = 1;
    localparam int NBIG  = 65535;

    logic clk = 1'b0;
    logic rst_16 = 1'b0, rst_1 = 1'b0, rst_big = 1'b0;
    logic o_16, on_16, o_1, on_1, o_big, on_big;

    int vectors     = 0;
    int miscompares = 0;
    int t_edge      = 0;

    logic [16:0] exp_q0[$];
    logic [16:0] exp_q1[$];
    logic [16:0] exp_q2[$];

    int unsigned last_hi[3] = '{0, 0, 0};

    rst_gen #(.RST_CYCLES(N16))  dut_16  (.clk_i(clk), .rst_i(rst_16),  .rst_o(o_16),  .rst_n_o(on_16));
    rst_gen #(.RST_CYCLES(N1))   dut_1   (.clk_i(clk), .rst_i(rst_1),   .rst_o(o_1),   .rst_n_o(on_1));
    rst_gen #(.RST_CYCLES(NBIG)) dut_big (.clk_i(clk), .rst_i(rst_big), .rst_o(o_big), .rst_n_o(on_big));

    // clock / edge timestamp
    always #5 clk = ~clk;
    always @(posedge clk) t_edge = $time;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at t=%0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Directed schedule for the 16-cycle instance, random afterwards.
    function automatic logic stim16(input int e);
        if (e <= 20)                return 1'b0;  // power-up release at edge 16
        if (e == 30)                return 1'b1;  // single pulse, then 1000 quiet cycles
        if (e < 1100)               return 1'b0;
        if (e == 1100 || e == 1111) return 1'b1;  // second pulse lands when cnt = 10
        if (e < 1200)               return 1'b0;
        if (e < 1250)               return 1'b1;  // 50-cycle long reset
        if (e < 1400)               return 1'b0;
        return ($urandom_range(0, 19) == 0);
    endfunction

    // Reference: rst_o is high iff fewer than N edges have passed since the last high sample.
    function automatic logic [16:0] model(input int unsigned e, input int c, input int unsigned n);
        int unsigned d;
        int unsigned cv;
        d  = e - last_hi[c];
        cv = (d < n) ? d : n;
        return {cv[15:0], (d < n)};
    endfunction

    task automatic check_chan(input string tag, input logic [16:0] ex,
                              input logic o, input logic on, input logic [15:0] cv);
        check({tag, ".rst_o"},   {31'd0, o},  {31'd0, ex[0]});
        check({tag, ".rst_n_o"}, {31'd0, on}, {31'd0, ~ex[0]});
        check({tag, ".cnt"},     {16'd0, cv}, {16'd0, ex[16:1]});
    endtask

    // monitor: one output sample per clock period, away from the active edge
    always @(negedge clk) begin
        if (exp_q0.size() > 0) check_chan("n16", exp_q0.pop_front(), o_16, on_16, 16'(dut_16.cnt));
        if (exp_q1.size() > 0) check_chan("n1", exp_q1.pop_front(), o_1, on_1, 16'(dut_1.cnt));
        if (exp_q2.size() > 0) check_chan("nbig", exp_q2.pop_front(), o_big, on_big, 16'(dut_big.cnt));
    end

    // rst_o may only change in the time step of a rising edge
    always @(o_16)  if ($time != 0) check("n16.edge_aligned",  $time, t_edge);
    always @(o_1)   if ($time != 0) check("n1.edge_aligned",   $time, t_edge);
    always @(o_big) if ($time != 0) check("nbig.edge_aligned", $time, t_edge);

    // driver + model
    initial begin
        rst_16  = stim16(1);
        rst_1   = 1'b0;
        rst_big = 1'b0;
        #1;
        check("n16.por_rst_o",    {31'd0, o_16},    32'd1);
        check("n16.por_rst_n_o",  {31'd0, on_16},   32'd0);
        check("n16.por_cnt",      32'(dut_16.cnt),  32'd0);
        check("n1.por_rst_o",     {31'd0, o_1},     32'd1);
        check("n1.por_rst_n_o",   {31'd0, on_1},    32'd0);
        check("nbig.por_rst_o",   {31'd0, o_big},   32'd1);
        check("nbig.por_cnt",     32'(dut_big.cnt), 32'd0);

        for (int e = 1; e <= TOTAL; e++) begin
            @(posedge clk);
            if (rst_16)  last_hi[0] = e;
            if (rst_1)   last_hi[1] = e;
            if (rst_big) last_hi[2] = e;
            exp_q0.push_back(model(e, 0, N16));
            exp_q1.push_back(model(e, 1, N1));
            exp_q2.push_back(model(e, 2, NBIG));
            #1;
            rst_16  = stim16(e + 1);
            rst_1   = ($urandom_range(0, 3) == 0);
            rst_big = ((e + 1) == 65560);
        end

        @(negedge clk);
        #1;
        check("queues_drained", exp_q0.size() + exp_q1.size() + exp_q2.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
